// File: rtl/sr_mon_pkg.sv
// rtl/sr_mon_pkg.sv - shared types, limits and next-state helper for the SR latch monitor
package sr_mon_pkg;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        Q0      = 2'd1,
        Q1      = 2'd2
    } sr_state_t;

    typedef struct packed {
        logic known;
        logic q;
    } sr_exp_t;

    localparam int SR_MON_SETTLE_MAX = 8;

    // set_req/rst_req are already polarity-corrected by the caller
    function automatic sr_state_t sr_next(sr_state_t cur, logic en, logic set_req, logic rst_req);
        sr_state_t nxt;
        nxt = cur;
        if (en) begin
            case ({set_req, rst_req})
                2'b10:   nxt = Q1;
                2'b01:   nxt = Q0;
                2'b11:   nxt = UNKNOWN;
                default: nxt = cur;
            endcase
        end
        return nxt;
    endfunction

    function automatic sr_exp_t sr_to_exp(sr_state_t st);
        sr_exp_t x;
        x.known = (st != UNKNOWN);
        x.q     = (st == Q1);
        return x;
    endfunction

endpackage

// File: rtl/sr_mon_delay.sv
// rtl/sr_mon_delay.sv - SETTLE-stage shift register of expected latch values, reset to unknown
module sr_mon_delay
    import sr_mon_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic    clock,
    input  logic    reset,
    input  sr_exp_t d,
    output sr_exp_t tap
);

    sr_exp_t stages [SETTLE];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SETTLE; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < SETTLE; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tap = stages[SETTLE-1];

endmodule

// File: rtl/sr_latch_monitor.sv
// rtl/sr_latch_monitor.sv - SR latch reference model, delayed response check and event counters
// Build option SR_MON_ACTIVE_LOW_EN: treat s/r as active-low (NAND latch convention).
module sr_latch_monitor
    import sr_mon_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s,
    input  logic             r,
    input  logic             e,
    input  logic             q_obs,
    output logic             exp_q,
    output logic             exp_known,
    output logic             mismatch,
    output logic             invalid,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] invalid_count
);

    if (SETTLE < 1 || SETTLE > SR_MON_SETTLE_MAX) begin : g_bad_settle
        $error("sr_latch_monitor: SETTLE out of range 1..%0d", SR_MON_SETTLE_MAX);
    end

    logic set_req;
    logic rst_req;

`ifdef SR_MON_ACTIVE_LOW_EN
    assign set_req = ~s;
    assign rst_req = ~r;
`else
    assign set_req = s;
    assign rst_req = r;
`endif

    sr_state_t state;
    sr_state_t state_nxt;
    sr_exp_t   tap;
    logic      invalid_req;
    logic      mismatch_now;

    assign state_nxt   = sr_next(state, e, set_req, rst_req);
    assign invalid_req = e & set_req & rst_req;

    // The delay line is fed with the post-edge model value, so stage 0 mirrors
    // the state register and the tap lags the model by SETTLE-1 cycles.
    sr_mon_delay #(
        .SETTLE (SETTLE)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .d     (sr_to_exp(state_nxt)),
        .tap   (tap)
    );

    assign mismatch_now = tap.known & (q_obs != tap.q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= UNKNOWN;
            exp_q     <= 1'b0;
            exp_known <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            state     <= state_nxt;
            exp_q     <= (state_nxt == Q1);
            exp_known <= (state_nxt != UNKNOWN);
            invalid   <= invalid_req;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mismatch       <= 1'b0;
            mismatch_count <= '0;
            invalid_count  <= '0;
        end else begin
            mismatch <= mismatch_now;
            if (mismatch_now && (mismatch_count != {CNT_W{1'b1}})) begin
                mismatch_count <= mismatch_count + 1'b1;
            end
            if (invalid_req && (invalid_count != {CNT_W{1'b1}})) begin
                invalid_count <= invalid_count + 1'b1;
            end
        end
    end

endmodule
